// File: rtl/riscv_ctrl_pkg.sv
// Shared types and constants for the RV32I control sequencer.
package riscv_ctrl_pkg;

   // Major opcodes the sequencer understands
   localparam logic [6:0] OP_R     = 7'b0110011;
   localparam logic [6:0] OP_I     = 7'b0010011;
   localparam logic [6:0] OP_LOAD  = 7'b0000011;
   localparam logic [6:0] OP_STORE = 7'b0100011;
   localparam logic [2:0] F3_WORD  = 3'b010;

   // ALUSel encodings expected by the datapath
   localparam logic [3:0] ALU_AND  = 4'b0000;
   localparam logic [3:0] ALU_OR   = 4'b0001;
   localparam logic [3:0] ALU_ADD  = 4'b0010;
   localparam logic [3:0] ALU_XOR  = 4'b0011;
   localparam logic [3:0] ALU_SLL  = 4'b0100;
   localparam logic [3:0] ALU_SRL  = 4'b0101;
   localparam logic [3:0] ALU_SUB  = 4'b0110;
   localparam logic [3:0] ALU_SLT  = 4'b0111;
   localparam logic [3:0] ALU_SRA  = 4'b1000;
   localparam logic [3:0] ALU_SLTU = 4'b1001;

   typedef enum logic [2:0] {
      ST_IDLE, ST_FETCH, ST_DECODE, ST_EXEC, ST_MEM, ST_WB, ST_TRAP
   } state_t;

   typedef enum logic [1:0] {
      CLS_ALU, CLS_LOAD, CLS_STORE, CLS_NONE
   } class_t;

   // Packs in the same order as {RegWEn,BSel,ALUSel,MEMRead,MEMWrite,WBSel}
   typedef struct packed {
      logic       reg_wen;
      logic       b_sel;
      logic [3:0] alu_sel;
      logic       mem_read;
      logic       mem_write;
      logic       wb_sel;
   } ctrl_t;

   // alt selects sub over add and sra over srl; ignored for other funct3 values
   function automatic logic [3:0] alu_from_funct(input logic [2:0] f3, input logic alt);
      logic [3:0] op;
      case (f3)
         3'b000:  op = alt ? ALU_SUB : ALU_ADD;
         3'b001:  op = ALU_SLL;
         3'b010:  op = ALU_SLT;
         3'b011:  op = ALU_SLTU;
         3'b100:  op = ALU_XOR;
         3'b101:  op = alt ? ALU_SRA : ALU_SRL;
         3'b110:  op = ALU_OR;
         default: op = ALU_AND;
      endcase
      return op;
   endfunction

endpackage

// File: rtl/riscv_ctrl_decode.sv
// Combinational instruction classifier: class, ALU op, B-operand select, rd!=0, legality.
module riscv_ctrl_decode
   import riscv_ctrl_pkg::*;
(
   input  logic [31:0] instr,
   output class_t      cls,
   output logic [3:0]  alu_sel,
   output logic        b_sel,
   output logic        rd_nz,
   output logic        legal
);

   logic [6:0] opcode;
   logic [2:0] funct3;
   logic       unused_bits;

   assign opcode      = instr[6:0];
   assign funct3      = instr[14:12];
   assign rd_nz       = |instr[11:7];
   assign unused_bits = ^{instr[31], instr[29:15]};

   // Classify by opcode; I-type only treats bit30 as an alternate op for shifts right (srai)
   always_comb begin
      cls     = CLS_NONE;
      alu_sel = ALU_ADD;
      b_sel   = 1'b0;
      legal   = 1'b0;
      case (opcode)
         OP_R: begin
            cls     = CLS_ALU;
            alu_sel = alu_from_funct(funct3, instr[30]);
            legal   = 1'b1;
         end
         OP_I: begin
            cls     = CLS_ALU;
            alu_sel = alu_from_funct(funct3, instr[30] && (funct3 == 3'b101));
            b_sel   = 1'b1;
            legal   = 1'b1;
         end
         OP_LOAD: begin
            cls   = CLS_LOAD;
            b_sel = 1'b1;
            legal = (funct3 == F3_WORD);
         end
         OP_STORE: begin
            cls   = CLS_STORE;
            b_sel = 1'b1;
            legal = (funct3 == F3_WORD);
         end
         default: ;
      endcase
   end

endmodule

// File: rtl/riscv_ctrl_seq.sv
// Multi-cycle RV32I control sequencer: FSM, PC, instruction register.
// Optional performance counters are built when CTRL_PERF_CNT_EN is defined.
module riscv_ctrl_seq
   import riscv_ctrl_pkg::*;
#(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter int unsigned PC_STEP  = 4
) (
   input  logic        CLK,
   input  logic        resetN,
   input  logic        run,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_ack,
   input  logic [31:0] imem_rdata,
   output logic [31:0] instructionCode,
   output logic        RegWEn,
   output logic        BSel,
   output logic [3:0]  ALUSel,
   output logic        MEMRead,
   output logic        MEMWrite,
   output logic        WBSel,
   input  logic        dmem_ready,
`ifdef CTRL_PERF_CNT_EN
   output logic [31:0] cycle_cnt,
   output logic [31:0] instret_cnt,
`endif
   output logic        busy,
   output logic        retire,
   output logic        illegal
);

   state_t      state, state_next;
   logic [31:0] pc;
   ctrl_t       ctrl;
   class_t      cls;
   logic [3:0]  dec_alu;
   logic        dec_bsel, rd_nz, legal;

   riscv_ctrl_decode u_decode (
      .instr   (instructionCode),
      .cls     (cls),
      .alu_sel (dec_alu),
      .b_sel   (dec_bsel),
      .rd_nz   (rd_nz),
      .legal   (legal)
   );

   // Controls are a pure function of state so an async reset clears them immediately
   assign {RegWEn, BSel, ALUSel, MEMRead, MEMWrite, WBSel} = ctrl;
   assign imem_addr = pc;
   assign busy      = (state != ST_IDLE) && (state != ST_TRAP);
   assign illegal   = (state == ST_TRAP);

   // State, PC and instruction register
   always_ff @(posedge CLK or negedge resetN) begin
      if (!resetN) begin
         state           <= ST_IDLE;
         pc              <= RESET_PC;
         instructionCode <= '0;
      end else begin
         state <= state_next;
         if (retire)
            pc <= pc + 32'(PC_STEP);
         if (state == ST_FETCH && imem_ack)
            instructionCode <= imem_rdata;
      end
   end

   // Next state and per-phase datapath controls
   always_comb begin
      state_next = state;
      ctrl       = '0;
      imem_req   = 1'b0;
      retire     = 1'b0;
      case (state)
         ST_IDLE:
            if (run) state_next = ST_FETCH;
         ST_FETCH: begin
            imem_req = 1'b1;
            if (imem_ack) state_next = ST_DECODE;
         end
         ST_DECODE: begin
            if (!legal)              state_next = ST_TRAP;
            else if (cls == CLS_ALU) state_next = ST_EXEC;
            else                     state_next = ST_MEM;
         end
         ST_EXEC: begin
            ctrl       = '{reg_wen: rd_nz, b_sel: dec_bsel, alu_sel: dec_alu,
                           mem_read: 1'b0, mem_write: 1'b0, wb_sel: 1'b1};
            retire     = 1'b1;
            state_next = run ? ST_FETCH : ST_IDLE;
         end
         ST_MEM: begin
            ctrl = '{reg_wen: 1'b0, b_sel: 1'b1, alu_sel: ALU_ADD,
                     mem_read: (cls == CLS_LOAD), mem_write: (cls == CLS_STORE), wb_sel: 1'b0};
            if (dmem_ready) begin
               if (cls == CLS_LOAD) begin
                  state_next = ST_WB;
               end else begin
                  retire     = 1'b1;
                  state_next = run ? ST_FETCH : ST_IDLE;
               end
            end
         end
         ST_WB: begin
            ctrl       = '{reg_wen: rd_nz, b_sel: 1'b1, alu_sel: ALU_ADD,
                           mem_read: 1'b0, mem_write: 1'b0, wb_sel: 1'b0};
            retire     = 1'b1;
            state_next = run ? ST_FETCH : ST_IDLE;
         end
         ST_TRAP: ;
         default: state_next = ST_IDLE;
      endcase
   end

`ifdef CTRL_PERF_CNT_EN
   // Busy-cycle and retired-instruction counters, free-running and wrapping
   always_ff @(posedge CLK or negedge resetN) begin
      if (!resetN) begin
         cycle_cnt   <= '0;
         instret_cnt <= '0;
      end else begin
         if (busy)   cycle_cnt   <= cycle_cnt + 32'd1;
         if (retire) instret_cnt <= instret_cnt + 32'd1;
      end
   end
`endif

endmodule

// File: tb/tb_riscv_ctrl_seq.sv
// Directed testbench for riscv_ctrl_seq. Reset PC is placed just below 2^32 so the PC wrap is exercised.
module tb_riscv_ctrl_seq;

   localparam logic [31:0] RP = 32'hFFFF_FFF8;

   logic        CLK, resetN, run, imem_ack, dmem_ready;
   logic [31:0] imem_rdata;
   logic        imem_req, RegWEn, BSel, MEMRead, MEMWrite, WBSel, busy, retire, illegal;
   logic [31:0] imem_addr, instructionCode;
   logic [3:0]  ALUSel;
`ifdef CTRL_PERF_CNT_EN
   logic [31:0] cycle_cnt, instret_cnt;
`endif

   riscv_ctrl_seq #(.RESET_PC(RP), .PC_STEP(4)) dut (
      .CLK             (CLK),
      .resetN          (resetN),
      .run             (run),
      .imem_req        (imem_req),
      .imem_addr       (imem_addr),
      .imem_ack        (imem_ack),
      .imem_rdata      (imem_rdata),
      .instructionCode (instructionCode),
      .RegWEn          (RegWEn),
      .BSel            (BSel),
      .ALUSel          (ALUSel),
      .MEMRead         (MEMRead),
      .MEMWrite        (MEMWrite),
      .WBSel           (WBSel),
      .dmem_ready      (dmem_ready),
`ifdef CTRL_PERF_CNT_EN
      .cycle_cnt       (cycle_cnt),
      .instret_cnt     (instret_cnt),
`endif
      .busy            (busy),
      .retire          (retire),
      .illegal         (illegal)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   logic [8:0]  ctrl_obs;
   assign ctrl_obs = {RegWEn, BSel, ALUSel, MEMRead, MEMWrite, WBSel};

   int          n_checks = 0;
   int          n_errors = 0;
   logic [31:0] pc_model;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   // Bounded wait for a fetch request; leaves us just after a falling edge
   task automatic wait_req();
      int n = 0;
      while (imem_req !== 1'b1 && n < 20) begin
         @(negedge CLK); #1;
         n++;
      end
      check("fetch_req", {31'd0, imem_req}, 32'd1);
   endtask

   // Single-cycle fetch (ack in the first FETCH cycle), then check the DECODE cycle
   task automatic do_fetch(input string tag, input logic [31:0] instr);
      wait_req();
      check({tag, "_addr"}, imem_addr, pc_model);
      imem_ack   = 1'b1;
      imem_rdata = instr;
      @(negedge CLK);
      imem_ack   = 1'b0;
      imem_rdata = '0;
      #1;
      check({tag, "_ir"},       instructionCode, instr);
      check({tag, "_dec_ctrl"}, {23'd0, ctrl_obs}, 32'd0);
      check({tag, "_dec_busy"}, {31'd0, busy}, 32'd1);
   endtask

   task automatic do_alu(input string tag, input logic [31:0] instr,
                         input logic [8:0] exp_ctrl, input bit stop);
      do_fetch(tag, instr);
      if (stop) run = 1'b0;
      @(negedge CLK); #1;
      check({tag, "_exec_ctrl"}, {23'd0, ctrl_obs}, {23'd0, exp_ctrl});
      check({tag, "_retire"},    {31'd0, retire}, 32'd1);
      pc_model = pc_model + 32'd4;
      @(negedge CLK); #1;
      check({tag, "_next_pc"}, imem_addr, pc_model);
      check({tag, "_next_req"}, {31'd0, imem_req}, stop ? 32'd0 : 32'd1);
      if (stop) begin
         check({tag, "_idle_busy"}, {31'd0, busy}, 32'd0);
         run = 1'b1;
      end
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      resetN = 1'b0; run = 1'b0; imem_ack = 1'b0; imem_rdata = '0; dmem_ready = 1'b0;
      pc_model = RP;
      @(negedge CLK); @(negedge CLK); #1;
      check("rst_addr", imem_addr, RP);
      check("rst_ir",   instructionCode, 32'd0);
      check("rst_ctrl", {23'd0, ctrl_obs}, 32'd0);
      check("rst_flags", {28'd0, imem_req, busy, retire, illegal}, 32'd0);
      resetN = 1'b1;
      run    = 1'b1;

      // ALU instructions; third one fetches from address 0 after the PC wraps
      do_alu("addi", 32'h0030_0093, 9'b110010001, 1'b0);
      do_alu("add",  32'h0020_81B3, 9'b100010001, 1'b0);
      do_alu("sub",  32'h4020_81B3, 9'b100110001, 1'b0);
      do_alu("srai", 32'h4030_D093, 9'b111000001, 1'b0);
      do_alu("addi_neg", 32'hC000_0093, 9'b110010001, 1'b0);
      do_alu("nop_stop", 32'h0000_0013, 9'b010010001, 1'b1);

      // sw x14,8(x2): DMEM not ready for two cycles
      do_fetch("sw", 32'h00E1_2423);
      for (int i = 0; i < 3; i++) begin
         @(negedge CLK);
         if (i == 2) dmem_ready = 1'b1;
         #1;
         check("sw_mem_ctrl", {23'd0, ctrl_obs}, {23'd0, 9'b010010010});
         check("sw_retire",   {31'd0, retire}, (i == 2) ? 32'd1 : 32'd0);
      end
      pc_model = pc_model + 32'd4;
      @(negedge CLK); dmem_ready = 1'b0; #1;
      check("sw_next_pc",   imem_addr, pc_model);
      check("sw_next_ctrl", {23'd0, ctrl_obs}, 32'd0);

      // lw x15,8(x2): one wait cycle, then a single WB cycle
      do_fetch("lw", 32'h0081_2783);
      @(negedge CLK); #1;
      check("lw_mem_wait", {23'd0, ctrl_obs}, {23'd0, 9'b010010100});
      check("lw_mem_ret",  {31'd0, retire}, 32'd0);
      @(negedge CLK); dmem_ready = 1'b1; #1;
      check("lw_mem_rdy",  {23'd0, ctrl_obs}, {23'd0, 9'b010010100});
      check("lw_rdy_ret",  {31'd0, retire}, 32'd0);
      @(negedge CLK); dmem_ready = 1'b0; #1;
      check("lw_wb_ctrl",  {23'd0, ctrl_obs}, {23'd0, 9'b110010000});
      check("lw_wb_ret",   {31'd0, retire}, 32'd1);
      pc_model = pc_model + 32'd4;
      @(negedge CLK); #1;
      check("lw_after_wb", {23'd0, ctrl_obs}, 32'd0);
      check("lw_next_pc",  imem_addr, pc_model);
`ifdef CTRL_PERF_CNT_EN
      check("instret_cnt", instret_cnt, 32'd8);
`endif

      // Asynchronous reset in the middle of a load's DMEM wait
      do_fetch("lw_rst", 32'h0081_2783);
      @(negedge CLK); #1;
      check("lwr_memread", {31'd0, MEMRead}, 32'd1);
      #2;
      resetN = 1'b0;
      run    = 1'b0;
      #1;
      check("lwr_ctrl",   {23'd0, ctrl_obs}, 32'd0);
      check("lwr_retire", {31'd0, retire}, 32'd0);
      check("lwr_pc",     imem_addr, RP);
      check("lwr_busy",   {31'd0, busy}, 32'd0);
      @(negedge CLK);
      resetN   = 1'b1;
      pc_model = RP;
      repeat (3) @(negedge CLK);
      #1;
      check("lwr_idle", {30'd0, busy, imem_req}, 32'd0);

      // Illegal instruction traps until reset
      run = 1'b1;
      do_fetch("ill", 32'hFFFF_FFFF);
      @(negedge CLK); #1;
      check("ill_flag", {31'd0, illegal}, 32'd1);
      check("ill_busy", {31'd0, busy}, 32'd0);
      repeat (5) @(negedge CLK);
      #1;
      check("ill_req",    {31'd0, imem_req}, 32'd0);
      check("ill_sticky", {31'd0, illegal}, 32'd1);
      check("ill_pc",     imem_addr, pc_model);
      resetN = 1'b0;
      #1;
      check("ill_cleared", {31'd0, illegal}, 32'd0);
      @(negedge CLK);
      resetN = 1'b1;
      run    = 1'b0;

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
